alu_exec: RTL

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_exec_pkg.sv | 26 ++
 rtl/alu_exec_alu.sv | 62 ++++++
 rtl/alu_exec.sv | 132 +++++++++++++
 3 files changed

// File: rtl/alu_exec_pkg.sv
// Shared types for the alu_exec slice: FSM states, ALU opcode and shift encodings, default width.
package alu_exec_pkg;
  localparam int W_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOADA = 3'd1,
    S_LOADB = 3'd2,
    S_EXEC  = 3'd3,
    S_WB    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_NOT = 2'b11
  } aluop_t;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL1 = 2'b01,
    SH_LSR1 = 2'b10,
    SH_ASR1 = 2'b11
  } shift_t;
endpackage

// File: rtl/alu_exec_alu.sv
// Combinational execute stage: B shifter, operand select, ALU and z/n/v flags.
// Signed overflow is only produced when ALU_EXEC_OVF_EN is defined; otherwise v is 0.
module exec_alu
  import alu_exec_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] imm,
  input  aluop_t       aluop,
  input  shift_t       shift,
  input  logic         bsel_imm,
  output logic [W-1:0] c,
  output logic         z,
  output logic         n,
  output logic         v
);
  logic [W-1:0] b_sh;
  logic [W-1:0] b_sel;

  always_comb begin
    b_sh = b;
    case (shift)
      SH_NONE: b_sh = b;
      SH_LSL1: b_sh = {b[W-2:0], 1'b0};
      SH_LSR1: b_sh = {1'b0, b[W-1:1]};
      SH_ASR1: b_sh = {b[W-1], b[W-1:1]};
      default: b_sh = b;
    endcase
  end

  assign b_sel = bsel_imm ? imm : b_sh;

  always_comb begin
    c = '0;
    case (aluop)
      OP_ADD:  c = a + b_sel;
      OP_SUB:  c = a - b_sel;
      OP_AND:  c = a & b_sel;
      OP_NOT:  c = ~b_sel;
      default: c = '0;
    endcase
  end

  assign z = (c == '0);
  assign n = c[W-1];

`ifdef ALU_EXEC_OVF_EN
  // Overflow when the result sign disagrees with what the operand signs allow.
  always_comb begin
    v = 1'b0;
    case (aluop)
      OP_ADD:  v = (a[W-1] == b_sel[W-1]) && (c[W-1] != a[W-1]);
      OP_SUB:  v = (a[W-1] != b_sel[W-1]) && (c[W-1] != a[W-1]);
      default: v = 1'b0;
    endcase
  end
`else
  assign v = 1'b0;
`endif
endmodule

// File: rtl/alu_exec.sv
// Multi-cycle register-file ALU: IDLE -> LOADA -> LOADB -> EXEC -> WB, one cycle per state.
// Optional signed-overflow flag is enabled by defining ALU_EXEC_OVF_EN.
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   rn,
  input  logic [2:0]   rm,
  input  logic [2:0]   rd,
  input  logic [1:0]   aluop,
  input  logic [1:0]   shift,
  input  logic         bsel_imm,
  input  logic [W-1:0] imm,
  input  logic [W-1:0] rf_data,
  output logic [2:0]   readnum,
  output logic [2:0]   writenum,
  output logic         write,
  output logic [W-1:0] data_in,
  output logic         busy,
  output logic         done,
  output logic         z,
  output logic         n,
  output logic         v,
  output state_t       dbg_state
);
  // Handshake: start is a request sampled only in IDLE; there is no ready signal,
  // busy=1 means any start is dropped. done/write pulse for exactly the WB cycle.
  state_t       state;
  logic [2:0]   rn_q, rm_q, rd_q;
  aluop_t       aluop_q;
  shift_t       shift_q;
  logic         bsel_q;
  logic [W-1:0] imm_q, a_q, b_q, c_q;
  logic [W-1:0] alu_c;
  logic         alu_z, alu_n, alu_v;

  exec_alu #(.W(W)) u_alu (
    .a        (a_q),
    .b        (b_q),
    .imm      (imm_q),
    .aluop    (aluop_q),
    .shift    (shift_q),
    .bsel_imm (bsel_q),
    .c        (alu_c),
    .z        (alu_z),
    .n        (alu_n),
    .v        (alu_v)
  );

  assign data_in   = c_q;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      rn_q     <= '0;
      rm_q     <= '0;
      rd_q     <= '0;
      aluop_q  <= OP_ADD;
      shift_q  <= SH_NONE;
      bsel_q   <= 1'b0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      z        <= 1'b0;
      n        <= 1'b0;
      v        <= 1'b0;
      readnum  <= '0;
      writenum <= '0;
      write    <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            rn_q    <= rn;
            rm_q    <= rm;
            rd_q    <= rd;
            aluop_q <= aluop_t'(aluop);
            shift_q <= shift_t'(shift);
            bsel_q  <= bsel_imm;
            imm_q   <= imm;
            readnum <= rn;
            busy    <= 1'b1;
            state   <= S_LOADA;
          end
        end
        S_LOADA: begin
          a_q     <= rf_data;
          readnum <= rm_q;
          state   <= S_LOADB;
        end
        S_LOADB: begin
          b_q     <= rf_data;
          readnum <= '0;
          state   <= S_EXEC;
        end
        S_EXEC: begin
          c_q      <= alu_c;
          z        <= alu_z;
          n        <= alu_n;
          v        <= alu_v;
          writenum <= rd_q;
          write    <= 1'b1;
          done     <= 1'b1;
          state    <= S_WB;
        end
        S_WB: begin
          writenum <= '0;
          write    <= 1'b0;
          done     <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          readnum  <= '0;
          writenum <= '0;
          write    <= 1'b0;
          done     <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end
endmodule
